// File: rtl/risc_toy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc_toy_pkg
//  Description : Shared definitions for the RISC_TOY hazard controller.
//                Forwarding-select encodings, the hardwired-zero register
//                address, the stage-tag layouts, and a shared helper that
//                tests whether a stage tag produces a given source register.
//  Revision    : 1.0  initial release
// ============================================================================
package risc_toy_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FW_SRC = 2'b00;
    localparam logic [1:0] FW_MEM = 2'b01;
    localparam logic [1:0] FW_WB  = 2'b10;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    // Destination tag carried by every in-flight instruction.
    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [REG_AW-1:0] wa;
        logic              load;
    } tag_t;

    // The EX tag also remembers which sources the instruction consumes.
    typedef struct packed {
        tag_t              tag;
        logic              use0;
        logic [REG_AW-1:0] ra0;
        logic              use1;
        logic [REG_AW-1:0] ra1;
    } ex_tag_t;

    localparam int TAG_W    = $bits(tag_t);
    localparam int EX_TAG_W = $bits(ex_tag_t);

    // True when stage tag t writes the register that a consumer reads.
    // allow_load=0 excludes loads (their data is not ready yet in MEM).
    // r0_zero=1 makes register 0 never match.
    function automatic logic src_hit(input tag_t              t,
                                     input logic              src_use,
                                     input logic [REG_AW-1:0] src_ra,
                                     input logic              allow_load,
                                     input logic              r0_zero);
        return t.valid & t.wen & (allow_load | ~t.load) & src_use &
               (t.wa == src_ra) & ~(r0_zero & (src_ra == REG_ZERO));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hz_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : hz_sat_cnt
//  Description : Event counter that sticks at all-ones instead of wrapping.
//  Ports       : CLK  - clock (rising edge)
//                RSTN - asynchronous active-low reset, clears the count
//                INC  - count one event this cycle
//                CNT  - current count
//  Revision    : 1.0  initial release
// ============================================================================
module hz_sat_cnt #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         INC,
    output logic [W-1:0] CNT
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (INC && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT = cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard controller for the five-stage RISC_TOY pipeline.
//                Tracks destination tags of instructions in EX/MEM/WB,
//                produces EX forwarding selects, load-use stalls and
//                wrong-path flushes, and counts stall/flush events.
//  Ports       : CLK, RSTN             - clock, async active-low reset
//                ID_*                  - decoded fields of the ID instruction
//                EX_REDIRECT           - taken branch / jump resolved in EX
//                STALL_F/STALL_D       - hold PC / FD register
//                FLUSH_D/FLUSH_E       - bubble into FD / DE
//                FW1/FW2               - EX operand selects (00 rf, 01 MEM, 10 WB)
//                STALL_CNT/FLUSH_CNT   - saturating event counters
//  Config      : HAZ_R0_ZERO_EN - register 0 is hardwired zero and never
//                matches for forwarding or stall.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import risc_toy_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             ID_VALID,
    input  logic [4:0]       ID_RA0,
    input  logic [4:0]       ID_RA1,
    input  logic             ID_USE0,
    input  logic             ID_USE1,
    input  logic             ID_WEN,
    input  logic [4:0]       ID_WA,
    input  logic             ID_LOAD,
    input  logic             EX_REDIRECT,
    output logic             STALL_F,
    output logic             STALL_D,
    output logic             FLUSH_D,
    output logic             FLUSH_E,
    output logic [1:0]       FW1,
    output logic [1:0]       FW2,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

`ifdef HAZ_R0_ZERO_EN
    localparam logic R0_ZERO = 1'b1;
`else
    localparam logic R0_ZERO = 1'b0;
`endif

    ex_tag_t t_e_q, t_e_d;
    tag_t    t_m_q, t_w_q;

    logic    w_redirect;
    logic    w_load_use;
    logic    w_stall;

    always_comb begin
        // Redirect is an input, not a tag, so mask it while in reset to keep
        // every control output quiet.
        w_redirect = EX_REDIRECT & RSTN;

        w_load_use = t_e_q.tag.load &
                     (src_hit(t_e_q.tag, ID_VALID & ID_USE0, ID_RA0, 1'b1, R0_ZERO) |
                      src_hit(t_e_q.tag, ID_VALID & ID_USE1, ID_RA1, 1'b1, R0_ZERO));

        // A redirect squashes the dependent instruction anyway, so it wins.
        w_stall = w_load_use & ~w_redirect;

        STALL_F = w_stall;
        STALL_D = w_stall;
        FLUSH_D = w_redirect;
        FLUSH_E = w_redirect | w_load_use;

        FW1 = FW_SRC;
        if (src_hit(t_m_q, t_e_q.use0, t_e_q.ra0, 1'b0, R0_ZERO)) begin
            FW1 = FW_MEM;
        end else if (src_hit(t_w_q, t_e_q.use0, t_e_q.ra0, 1'b1, R0_ZERO)) begin
            FW1 = FW_WB;
        end

        FW2 = FW_SRC;
        if (src_hit(t_m_q, t_e_q.use1, t_e_q.ra1, 1'b0, R0_ZERO)) begin
            FW2 = FW_MEM;
        end else if (src_hit(t_w_q, t_e_q.use1, t_e_q.ra1, 1'b1, R0_ZERO)) begin
            FW2 = FW_WB;
        end

        t_e_d = '0;
        if (ID_VALID && !w_load_use && !w_redirect) begin
            t_e_d.tag.valid = 1'b1;
            t_e_d.tag.wen   = ID_WEN;
            t_e_d.tag.wa    = ID_WA;
            t_e_d.tag.load  = ID_LOAD;
            t_e_d.use0      = ID_USE0;
            t_e_d.ra0       = ID_RA0;
            t_e_d.use1      = ID_USE1;
            t_e_d.ra1       = ID_RA1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            t_e_q <= '0;
            t_m_q <= '0;
            t_w_q <= '0;
        end else begin
            t_e_q <= t_e_d;
            t_m_q <= t_e_q.tag;
            t_w_q <= t_m_q;
        end
    end

    hz_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .CLK  (CLK),
        .RSTN (RSTN),
        .INC  (w_stall),
        .CNT  (STALL_CNT)
    );

    hz_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .CLK  (CLK),
        .RSTN (RSTN),
        .INC  (w_redirect),
        .CNT  (FLUSH_CNT)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Scoreboard bench for hazard_ctrl (CNT_W = 4). Directed
//                vectors push hand-computed expectations; a monitor pops
//                and compares them against the DUT outputs.
//  Config      : HAZ_R0_ZERO_EN selects the r0-hardwired expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;
    import risc_toy_pkg::*;

`ifdef HAZ_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       id_valid = 1'b0, id_use0 = 1'b0, id_use1 = 1'b0;
    logic       id_wen = 1'b0, id_load = 1'b0, ex_redirect = 1'b0;
    logic [4:0] id_ra0 = '0, id_ra1 = '0, id_wa = '0;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic [1:0] fw1, fw2;
    logic [3:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(4)) dut (
        .CLK(clk), .RSTN(rstn),
        .ID_VALID(id_valid), .ID_RA0(id_ra0), .ID_RA1(id_ra1),
        .ID_USE0(id_use0), .ID_USE1(id_use1), .ID_WEN(id_wen),
        .ID_WA(id_wa), .ID_LOAD(id_load), .EX_REDIRECT(ex_redirect),
        .STALL_F(stall_f), .STALL_D(stall_d), .FLUSH_D(flush_d),
        .FLUSH_E(flush_e), .FW1(fw1), .FW2(fw2),
        .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
    );

    typedef struct {
        string      nm;
        logic       st;
        logic       fd;
        logic       fe;
        logic [1:0] fw1;
        logic [1:0] fw2;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   vectors = 0;
    int   miscompares = 0;

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                exp_t e;
                logic [15:0] got, want;
                e    = q.pop_front();
                got  = {stall_f, stall_d, flush_d, flush_e, fw1, fw2, stall_cnt, flush_cnt};
                want = {e.st, e.st, e.fd, e.fe, e.fw1, e.fw2, e.sc, e.fc};
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL %s: got sf=%b sd=%b fd=%b fe=%b fw1=%b fw2=%b sc=%0d fc=%0d, want sf=%b sd=%b fd=%b fe=%b fw1=%b fw2=%b sc=%0d fc=%0d",
                             e.nm, stall_f, stall_d, flush_d, flush_e, fw1, fw2, stall_cnt, flush_cnt,
                             e.st, e.st, e.fd, e.fe, e.fw1, e.fw2, e.sc, e.fc);
                end
                // A load in MEM feeding an EX source must never be reachable.
                if (dut.t_m_q.valid && dut.t_m_q.wen && dut.t_m_q.load &&
                    ((dut.t_e_q.use0 && dut.t_e_q.ra0 == dut.t_m_q.wa &&
                      !(R0Z && dut.t_e_q.ra0 == REG_ZERO)) ||
                     (dut.t_e_q.use1 && dut.t_e_q.ra1 == dut.t_m_q.wa &&
                      !(R0Z && dut.t_e_q.ra1 == REG_ZERO)))) begin
                    miscompares++;
                    $display("FAIL mem_load_fwd at %s: got MEM load r%0d feeding EX, want none",
                             e.nm, dut.t_m_q.wa);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic expect_now(input string nm, input logic st, input logic fd, input logic fe,
                              input logic [1:0] f1, input logic [1:0] f2,
                              input int sc, input int fc);
        exp_t e;
        e.nm = nm; e.st = st; e.fd = fd; e.fe = fe;
        e.fw1 = f1; e.fw2 = f2; e.sc = 4'(sc); e.fc = 4'(fc);
        q.push_back(e);
        -> sample_ev;
    endtask

    // One cycle: drive ID/EX inputs after the edge, then check the outputs.
    task automatic step(input string nm,
                        input logic v, input logic [4:0] ra0, input logic u0,
                        input logic [4:0] ra1, input logic u1,
                        input logic wen, input logic [4:0] wa, input logic ld,
                        input logic redir,
                        input logic st, input logic fd, input logic fe,
                        input logic [1:0] f1, input logic [1:0] f2,
                        input int sc, input int fc);
        @(posedge clk);
        #1;
        id_valid = v; id_ra0 = ra0; id_use0 = u0; id_ra1 = ra1; id_use1 = u1;
        id_wen = wen; id_wa = wa; id_load = ld; ex_redirect = redir;
        #2;
        expect_now(nm, st, fd, fe, f1, f2, sc, fc);
    endtask

    task automatic idle(input string nm, input logic [1:0] f1, input logic [1:0] f2,
                        input int sc, input int fc);
        step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, f1, f2, sc, fc);
    endtask

    initial begin
        int s;
        s = R0Z ? 1 : 2;

        // Reset state
        idle("rst_a", 2'b00, 2'b00, 0, 0);
        step("rst_redir", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        ex_redirect = 1'b0;
        rstn = 1'b1;
        idle("rst_after", 2'b00, 2'b00, 0, 0);

        // ALU result forwarded from MEM
        step("add_r3",   1, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step("use_r3_id",1, 3, 1, 4, 1, 1, 6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        idle("fw1_mem",  2'b01, 2'b00, 0, 0);
        idle("drain_a0", 2'b00, 2'b00, 0, 0);
        idle("drain_a1", 2'b00, 2'b00, 0, 0);

        // Load-use stall, then WB forwarding
        step("ld_r5",    1, 1, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step("lu_stall", 1, 8, 1, 5, 1, 1, 9, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0);
        step("lu_retry", 1, 8, 1, 5, 1, 1, 9, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        idle("fw2_wb",   2'b00, 2'b10, 1, 0);
        idle("drain_b0", 2'b00, 2'b00, 1, 0);
        idle("drain_b1", 2'b00, 2'b00, 1, 0);

        // Redirect overrides load-use
        step("ld_r5_b",  1, 1, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        step("redir_lu", 1, 8, 0, 5, 1, 1, 9, 0, 1, 0, 1, 1, 2'b00, 2'b00, 1, 0);
        idle("post_redir", 2'b00, 2'b00, 1, 1);
        idle("drain_c0", 2'b00, 2'b00, 1, 1);
        idle("drain_c1", 2'b00, 2'b00, 1, 1);

        // MEM has priority over WB
        step("add_r7a",  1, 1, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        step("add_r7b",  1, 2, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        step("rd_r7",    1, 7, 1, 7, 1, 1, 10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        idle("mem_prio", 2'b01, 2'b01, 1, 1);
        idle("drain_d0", 2'b00, 2'b00, 1, 1);
        idle("drain_d1", 2'b00, 2'b00, 1, 1);

        // Register 0 handling
        step("wr_r0",    1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        step("rd_r0",    1, 0, 1, 0, 0, 1, 11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        idle("r0_fw",    R0Z ? 2'b00 : 2'b01, 2'b00, 1, 1);
        idle("drain_e0", 2'b00, 2'b00, 1, 1);
        idle("drain_e1", 2'b00, 2'b00, 1, 1);
        step("ld_r0",    1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        step("r0_lu",    1, 0, 1, 0, 0, 1, 12, 0, 0, !R0Z, 0, !R0Z, 2'b00, 2'b00, 1, 1);
        idle("r0_lu_cnt", 2'b00, 2'b00, s, 1);
        idle("drain_e2", 2'b00, 2'b00, s, 1);
        idle("drain_e3", 2'b00, 2'b00, s, 1);

        // Back-to-back load-use
        step("ldA_r5",   1, 1, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, s, 1);
        step("ldB_stall",1, 5, 1, 0, 0, 1, 6, 1, 0, 1, 0, 1, 2'b00, 2'b00, s, 1);
        step("ldB_retry",1, 5, 1, 0, 0, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00, s + 1, 1);
        step("use_stall",1, 0, 0, 6, 1, 1, 13, 0, 0, 1, 0, 1, 2'b10, 2'b00, s + 1, 1);
        step("use_retry",1, 0, 0, 6, 1, 1, 13, 0, 0, 0, 0, 0, 2'b00, 2'b00, s + 2, 1);
        idle("use_fw_wb", 2'b00, 2'b10, s + 2, 1);
        idle("drain_f0", 2'b00, 2'b00, s + 2, 1);
        idle("drain_f1", 2'b00, 2'b00, s + 2, 1);

        // Asynchronous reset in the middle of a stall
        step("ld_r5_g",  1, 1, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, s + 2, 1);
        step("stall_g",  1, 5, 1, 0, 0, 1, 14, 0, 0, 1, 0, 1, 2'b00, 2'b00, s + 2, 1);
        #1 rstn = 1'b0;
        #1 expect_now("rst_mid_stall", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        #1 rstn = 1'b1;
        idle("rst_mid_after", 2'b00, 2'b00, 0, 0);

        // Flush counter saturation at CNT_W = 4
        for (int k = 0; k < 20; k++) begin
            step($sformatf("redir_%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 1,
                 0, 1, 1, 2'b00, 2'b00, 0, (k > 15) ? 15 : k);
        end
        idle("flush_sat", 2'b00, 2'b00, 0, 15);

        #5;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller for the five-stage RISC_TOY core (IF, ID, EX, MEM, WB).
- Tracks destination tags of in-flight instructions in EX/MEM/WB and drives:
  - forwarding selects for the EX operand muxes;
  - load-use stalls;
  - wrong-path flushes on taken branch/jump resolved in EX.
- Keeps saturating stall/flush event counters.
- Sits beside the FD/DE/EM/MW pipeline registers; owns all their stall/flush enables.

## Interface

Parameters:
- CNT_W, 16, width of each event counter

Ports:
- CLK  in  1  core clock; everything on rising edge
- RSTN  in  1  asynchronous active-low reset
- ID_VALID  in  1  ID holds a real instruction
- ID_RA0  in  5  first regfile read address in ID (rb, or ra for stores)
- ID_RA1  in  5  second regfile read address in ID (rc, or rb for stores)
- ID_USE0, ID_USE1  in  1 each  corresponding operand actually consumed (0 when immediate selected)
- ID_WEN  in  1  ID instruction writes a register
- ID_WA  in  5  its destination register
- ID_LOAD  in  1  ID instruction is a load (result available only at WB)
- EX_REDIRECT  in  1  Jump_E | (Branch_E & Taken_E)
- STALL_F  out  1  hold PC
- STALL_D  out  1  hold FD register
- FLUSH_D  out  1  clear FD to bubble
- FLUSH_E  out  1  load bubble into DE
- FW1, FW2  out  2 each  EX operand select: 00 regfile/imm, 01 ALUOUT_M, 10 WBData
- STALL_CNT, FLUSH_CNT  out  CNT_W each  event counters

## Operation

Tag pipeline:
- Internal tags T_E, T_M, T_W = {valid, wen, wa, load}.
- T_E additionally holds {use0, ra0, use1, ra1}.

Each cycle:
- T_W <= T_M; T_M <= T_E. No back-pressure from memory.
- T_E <= ID fields when ID_VALID & !load-use stall & !EX_REDIRECT; otherwise T_E <= invalid.

Load-use:
- Condition: T_E.valid & T_E.wen & T_E.load & ID_VALID & (source match on ID_RA0/ID_USE0 or ID_RA1/ID_USE1).
- Response, for exactly one cycle: STALL_F = STALL_D = FLUSH_E = 1.
- Next cycle the load is in MEM and the bubble is in EX, so no further stall.
- The dependent instruction reaches EX with the load in WB and forwards via 10.

Redirect:
- EX_REDIRECT = 1 gives FLUSH_D = FLUSH_E = 1 and STALL_F = STALL_D = 0, so the PC loads the target.
- Redirect overrides load-use in the same cycle: no stall, STALL_CNT unchanged.

Forwarding (combinational from tags), for each EX operand n:
- FWn = 01 if T_M.valid & T_M.wen & !T_M.load & T_M.wa == T_E.ran & T_E.usen.
- Else FWn = 10 if the same test holds against T_W (loads allowed).
- Else FWn = 00.
- MEM has priority over WB.
- A MEM-stage load matching an EX source is unreachable; the bench asserts this.

Regfile: REGFILE provides same-cycle write-to-read bypass. This block does not cover the WB-to-ID distance.

Counters:
- STALL_CNT +1 per load-use stall cycle.
- FLUSH_CNT +1 per EX_REDIRECT cycle.
- Both saturate at all-ones and never wrap.

## Timing

- STALL_*, FLUSH_*, FW*: combinational from inputs and registered tags, valid in the same cycle. Zero-cycle decision latency.
- Tags and counters update on the CLK rising edge.
- Reset (async, any time, including mid-stall):
  - all tags invalid; counters 0;
  - hence STALL_F = STALL_D = FLUSH_D = FLUSH_E = 0 and FW1 = FW2 = 00 while RSTN = 0 and in the first cycle after.
- Back-to-back load-use, each stall is independent:
  - load A in EX and dependent load B in ID: one stall;
  - then B in EX and its consumer in ID: a second stall.

## Configuration

- HAZ_R0_ZERO_EN defined: register 0 is hardwired zero.
  - Any match whose address is 5'd0 is ignored.
  - It never causes forwarding or stall.
- Not defined: r0 is treated as an ordinary register.

## Structure

- Shared package risc_toy_pkg holds:
  - FW_SRC = 2'b00, FW_MEM = 2'b01, FW_WB = 2'b10;
  - REG_ZERO = 5'd0;
  - the stage-tag field widths.
- Sub-module hz_sat_cnt:
  - parameter W; ports CLK, RSTN, INC, CNT;
  - saturating counter, instantiated twice.

## Test plan

- ADD r3 in EX→MEM, ADD using r3 (ID_USE0) now in EX → FW1 = 01, FW2 = 00, no stall.
- LD r5 in EX, ID reads r5 on RA1 with USE1 = 1 → one cycle STALL_F = STALL_D = FLUSH_E = 1; two cycles later FW2 = 10; STALL_CNT = 1.
- EX_REDIRECT = 1 in the same cycle as a load-use match → FLUSH_D = FLUSH_E = 1, STALL_F = 0, FLUSH_CNT = 1, STALL_CNT = 0.
- MEM and WB both write r7, EX reads r7 → FW = 01 (MEM priority).
- Write r0 then read r0:
  - with HAZ_R0_ZERO_EN: FW = 00, no stall;
  - without it: FW = 01.
- CNT_W = 4, 20 redirects → FLUSH_CNT = 15. RSTN pulsed low mid-stall → all outputs 0 immediately.
